sysid_checker: RTL and testbench

SYSID_CHECKER -- requirements
Module: sysid_checker

---
 rtl/sysid_checker_if.sv | 31 +++
 rtl/sysid_checker.sv | 147 ++++++++++++++
 tb/tb_sysid_checker.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_checker_if.sv
// -----------------------------------------------------------------------------
// sysid_checker_if
//   Bus between the checker and a zero-wait-state sysid slave.
//   valid/ready: the slave has no wait states, so sysid_read is the only
//   qualifier. sysid_readdata is combinational from sysid_address and is
//   taken on every rising edge at which sysid_read is high.
//
//   sysid_address  : word address (0 = system ID, 1 = timestamp)
//   sysid_read     : read strobe
//   sysid_readdata : 32-bit read data
//
//   master modport : checker side
//   slave modport  : sysid slave side
// -----------------------------------------------------------------------------
interface sysid_checker_if;
    logic        sysid_address;
    logic        sysid_read;
    logic [31:0] sysid_readdata;

    modport master (
        output sysid_address,
        output sysid_read,
        input  sysid_readdata
    );

    modport slave (
        input  sysid_address,
        input  sysid_read,
        output sysid_readdata
    );
endinterface

// File: rtl/sysid_checker.sv
// -----------------------------------------------------------------------------
// sysid_checker
//   Reads the system ID (address 0) and the timestamp (address 1) from a sysid
//   slave and compares them with the values this build expects. A check takes
//   four cycles: RD_ID, RD_TS, CMP, then a one-cycle done pulse in IDLE.
//
//   Parameters
//     EXP_ID        : expected system ID word
//     EXP_TIMESTAMP : expected timestamp word
//     PERIOD        : auto-check interval in cycles (used only with the macro)
//
//   Compile-time option
//     SYSID_CHECKER_PERIODIC_EN : start a check on its own after PERIOD idle
//                                 cycles, in addition to the start input.
//
//   Ports
//     clock, reset_n : rising-edge clock, asynchronous active-low reset
//     start          : request one check (sampled in IDLE only)
//     sysid          : sysid bus, master side
//     busy           : a check is in progress
//     done           : one-cycle pulse after a check completes
//     id_ok, ts_ok   : last captured words equal the expected values
//     pass           : id_ok && ts_ok
//     id_value       : last captured system ID word
//     ts_value       : last captured timestamp word
//     check_count    : completed checks since reset, saturating at 0xFFFF
//     state_dbg      : current FSM state (IDLE=0, RD_ID=1, RD_TS=2, CMP=3)
// -----------------------------------------------------------------------------
module sysid_checker #(
    parameter logic [31:0] EXP_ID        = 32'h0000_0000,
    parameter logic [31:0] EXP_TIMESTAMP = 32'h5BA8_A70B,
    parameter int unsigned PERIOD        = 1000000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    sysid_checker_if.master        sysid,
    output logic                   busy,
    output logic                   done,
    output logic                   id_ok,
    output logic                   ts_ok,
    output logic                   pass,
    output logic [31:0]            id_value,
    output logic [31:0]            ts_value,
    output logic [15:0]            check_count,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        CMP   = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] check_count_q;
    logic        start_req;

    if (PERIOD < 8) begin : g_period_check
        $error("sysid_checker: PERIOD must be at least 8");
    end

`ifdef SYSID_CHECKER_PERIODIC_EN
    localparam logic [31:0] PERIOD_LAST = 32'(PERIOD - 1);

    // Counts cycles spent in IDLE; it is already zero whenever a check ends
    // because it clears on the edge that starts the check.
    logic [31:0] idle_cnt;

    assign start_req = start || (idle_cnt == PERIOD_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= 32'd0;
        end else if (state == IDLE) begin
            if (start_req) begin
                idle_cnt <= 32'd0;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end
`else
    assign start_req = start;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            sysid.sysid_address <= 1'b0;
            sysid.sysid_read    <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            id_ok               <= 1'b0;
            ts_ok               <= 1'b0;
            pass                <= 1'b0;
            id_value            <= 32'd0;
            ts_value            <= 32'd0;
            check_count_q       <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_req) begin
                        state               <= RD_ID;
                        sysid.sysid_address <= 1'b0;
                        sysid.sysid_read    <= 1'b1;
                        busy                <= 1'b1;
                    end
                end
                RD_ID: begin
                    id_value            <= sysid.sysid_readdata;
                    state               <= RD_TS;
                    sysid.sysid_address <= 1'b1;
                end
                RD_TS: begin
                    ts_value            <= sysid.sysid_readdata;
                    state               <= CMP;
                    sysid.sysid_address <= 1'b0;
                    sysid.sysid_read    <= 1'b0;
                end
                CMP: begin
                    id_ok <= (id_value == EXP_ID);
                    ts_ok <= (ts_value == EXP_TIMESTAMP);
                    pass  <= (id_value == EXP_ID) && (ts_value == EXP_TIMESTAMP);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (check_count_q != 16'hFFFF) begin
                        check_count_q <= check_count_q + 16'd1;
                    end
                end
                default: begin
                    state               <= IDLE;
                    sysid.sysid_address <= 1'b0;
                    sysid.sysid_read    <= 1'b0;
                    busy                <= 1'b0;
                end
            endcase
        end
    end

    assign check_count = check_count_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_sysid_checker
//   Directed bench for sysid_checker. Inputs are driven on the falling edge,
//   outputs sampled on the falling edge. The sysid slave is a combinational
//   mux of two bench variables (id_word, ts_word).
// -----------------------------------------------------------------------------
module tb_sysid_checker;

`ifdef SYSID_CHECKER_PERIODIC_EN
    localparam int unsigned TB_PERIOD = 16;
`else
    localparam int unsigned TB_PERIOD = 1000000;
`endif
    localparam logic [31:0] TS_GOOD = 32'h5BA8_A70B;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        pass;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic [15:0] check_count;
    logic [1:0]  state_dbg;

    logic [31:0] id_word;
    logic [31:0] ts_word;

    int tests_run;
    int tests_failed;

    // Scoreboard of sysid addresses seen on read cycles.
    logic [0:0] exp_q[$];
    logic [0:0] obs_q[$];

    sysid_checker_if sysid_bus ();

    assign sysid_bus.sysid_readdata = sysid_bus.sysid_address ? ts_word : id_word;

    sysid_checker #(
        .EXP_ID        (32'h0000_0000),
        .EXP_TIMESTAMP (TS_GOOD),
        .PERIOD        (TB_PERIOD)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .sysid       (sysid_bus.master),
        .busy        (busy),
        .done        (done),
        .id_ok       (id_ok),
        .ts_ok       (ts_ok),
        .pass        (pass),
        .id_value    (id_value),
        .ts_value    (ts_value),
        .check_count (check_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- address monitor ----------------
    always @(negedge clock) begin
        if (sysid_bus.sysid_read === 1'b1) begin
            obs_q.push_back(sysid_bus.sysid_address);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        start   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Pulses start for one edge and waits (bounded) for done.
    task automatic run_check(input string name);
        bit seen;
        seen  = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s_done_timeout: got no done, required done within 8 cycles", name);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b1;
        start   = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, id_ok, ts_ok, pass, sysid_bus.sysid_read, sysid_bus.sysid_address} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {busy, done, id_ok, ts_ok, pass, sysid_bus.sysid_read, sysid_bus.sysid_address});
        end
        tests_run++;
        if ({id_value, ts_value, check_count, state_dbg} !== 82'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got id=%h ts=%h cnt=%h st=%0d required all 0",
                     id_value, ts_value, check_count, state_dbg);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        id_word = 32'h0000_0000;
        ts_word = TS_GOOD;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);                       // E0 passed: RD_ID
        start = 1'b0;
        tests_run++;
        if ({state_dbg, busy, sysid_bus.sysid_read, sysid_bus.sysid_address} !== 5'b01_1_1_0) begin
            tests_failed++;
            $display("FAIL basic_rd_id: got st=%0d busy=%b rd=%b addr=%b required st=1 busy=1 rd=1 addr=0",
                     state_dbg, busy, sysid_bus.sysid_read, sysid_bus.sysid_address);
        end
        @(negedge clock);                       // E1 passed: RD_TS
        tests_run++;
        if ({state_dbg, busy, sysid_bus.sysid_read, sysid_bus.sysid_address} !== 5'b10_1_1_1) begin
            tests_failed++;
            $display("FAIL basic_rd_ts: got st=%0d busy=%b rd=%b addr=%b required st=2 busy=1 rd=1 addr=1",
                     state_dbg, busy, sysid_bus.sysid_read, sysid_bus.sysid_address);
        end
        @(negedge clock);                       // E2 passed: CMP
        tests_run++;
        if ({state_dbg, busy, sysid_bus.sysid_read, done} !== 5'b11_1_0_0) begin
            tests_failed++;
            $display("FAIL basic_cmp: got st=%0d busy=%b rd=%b done=%b required st=3 busy=1 rd=0 done=0",
                     state_dbg, busy, sysid_bus.sysid_read, done);
        end
        @(negedge clock);                       // E3 passed: done cycle
        tests_run++;
        if ({done, busy, id_ok, ts_ok, pass} !== 5'b1_0_1_1_1) begin
            tests_failed++;
            $display("FAIL basic_result: got done=%b busy=%b id_ok=%b ts_ok=%b pass=%b required 1 0 1 1 1",
                     done, busy, id_ok, ts_ok, pass);
        end
        tests_run++;
        if (id_value !== 32'h0 || ts_value !== TS_GOOD || check_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL basic_values: got id=%h ts=%h cnt=%0d required id=0 ts=5ba8a70b cnt=1",
                     id_value, ts_value, check_count);
        end
        @(negedge clock);
        tests_run++;
        if ({done, sysid_bus.sysid_address, pass} !== 3'b0_0_1) begin
            tests_failed++;
            $display("FAIL basic_after: got done=%b addr=%b pass=%b required done=0 addr=0 pass=1",
                     done, sysid_bus.sysid_address, pass);
        end
    endtask

    task automatic test_mismatch();
        // Timestamp off by one in the LSB.
        id_word = 32'h0000_0000;
        ts_word = 32'h5BA8_A70C;
        run_check("ts_mis");
        tests_run++;
        if ({done, id_ok, ts_ok, pass} !== 4'b1_1_0_0 || ts_value !== 32'h5BA8_A70C || check_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL ts_mismatch: got done=%b id_ok=%b ts_ok=%b pass=%b ts=%h cnt=%0d required 1 1 0 0 5ba8a70c 2",
                     done, id_ok, ts_ok, pass, ts_value, check_count);
        end
        // ID wrong in the MSB only.
        id_word = 32'h8000_0000;
        ts_word = TS_GOOD;
        run_check("id_mis");
        tests_run++;
        if ({id_ok, ts_ok, pass} !== 3'b0_1_0 || id_value !== 32'h8000_0000 || check_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL id_mismatch: got id_ok=%b ts_ok=%b pass=%b id=%h cnt=%0d required 0 1 0 80000000 3",
                     id_ok, ts_ok, pass, id_value, check_count);
        end
        // Timestamp wrong in the upper half only.
        id_word = 32'h0000_0000;
        ts_word = 32'h5BA9_A70B;
        run_check("ts_hi");
        tests_run++;
        if ({id_ok, ts_ok, pass} !== 3'b1_0_0) begin
            tests_failed++;
            $display("FAIL ts_high_mismatch: got id_ok=%b ts_ok=%b pass=%b required 1 0 0", id_ok, ts_ok, pass);
        end
        // Results hold in IDLE even when the slave data changes.
        ts_word = TS_GOOD;
        id_word = 32'h1234_5678;
        repeat (3) @(negedge clock);
        tests_run++;
        if (id_value !== 32'h0 || ts_value !== 32'h5BA9_A70B || pass !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_idle: got id=%h ts=%h pass=%b required 0 5ba9a70b 0", id_value, ts_value, pass);
        end
        id_word = 32'h0;
    endtask

    task automatic test_ignore_start();
        int dones;
        logic [15:0] cnt0;
        cnt0  = check_count;
        dones = 0;
        start = 1'b1;                           // high across E0..E2 only
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (i == 2) start = 1'b0;
            if (done === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 1 || check_count !== cnt0 + 16'd1) begin
            tests_failed++;
            $display("FAIL ignore_start: got dones=%0d cnt=%0d required dones=1 cnt=%0d",
                     dones, check_count, cnt0 + 16'd1);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        int last_idx;
        int bad_gap;
        do_reset();
        id_word = 32'h0;
        ts_word = TS_GOOD;
        obs_q.delete();
        exp_q.delete();
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(1'b0);
            exp_q.push_back(1'b1);
        end
        dones    = 0;
        last_idx = -1;
        bad_gap  = 0;
        start    = 1'b1;
        for (int i = 0; i < 48; i++) begin
            @(negedge clock);
            if (i == 39) start = 1'b0;
            if (done === 1'b1) begin
                if (last_idx >= 0 && (i - last_idx) != 4) bad_gap++;
                last_idx = i;
                dones++;
            end
        end
        tests_run++;
        if (dones != 10 || bad_gap != 0) begin
            tests_failed++;
            $display("FAIL b2b_done: got dones=%0d bad_gaps=%0d required dones=10 bad_gaps=0", dones, bad_gap);
        end
        tests_run++;
        if (check_count !== 16'd10 || pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_count: got cnt=%0d pass=%b required cnt=10 pass=1", check_count, pass);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL b2b_addr_len: got %0d reads required %0d", obs_q.size(), exp_q.size());
        end else begin
            int bad;
            bad = 0;
            foreach (exp_q[j]) if (obs_q[j] !== exp_q[j]) bad++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL b2b_addr_seq: got %0d wrong addresses required 0", bad);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        do_reset();
        id_word = 32'hA5A5_0001;
        ts_word = TS_GOOD;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);                       // RD_ID
        start = 1'b0;
        @(negedge clock);                       // RD_TS, id captured
        tests_run++;
        if (state_dbg !== 2'd2 || id_value !== 32'hA5A5_0001) begin
            tests_failed++;
            $display("FAIL midreset_pre: got st=%0d id=%h required st=2 id=a5a50001", state_dbg, id_value);
        end
        #2 reset_n = 1'b0;                      // between clock edges
        #1;
        tests_run++;
        if ({busy, done, sysid_bus.sysid_read, sysid_bus.sysid_address, pass} !== 5'b0 ||
            id_value !== 32'h0 || check_count !== 16'd0 || state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL midreset_async: got busy=%b rd=%b addr=%b id=%h cnt=%0d st=%0d required all 0",
                     busy, sysid_bus.sysid_read, sysid_bus.sysid_address, id_value, check_count, state_dbg);
        end
        @(negedge clock);
        reset_n = 1'b1;
        dones   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 0 || check_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL midreset_nodone: got dones=%0d cnt=%0d required 0 0", dones, check_count);
        end
        id_word = 32'h0;
        run_check("after_reset");
        tests_run++;
        if (pass !== 1'b1 || check_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL midreset_recover: got pass=%b cnt=%0d required 1 1", pass, check_count);
        end
    endtask

    task automatic test_periodic();
        int first_done;
        do_reset();
        first_done = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clock);                   // rising edge i after release passed
            if (done === 1'b1 && first_done < 0) first_done = i;
        end
`ifdef SYSID_CHECKER_PERIODIC_EN
        tests_run++;
        if (first_done != 19) begin
            tests_failed++;
            $display("FAIL periodic_first: got first done after edge %0d required 19", first_done);
        end
`else
        tests_run++;
        if (first_done != -1) begin
            tests_failed++;
            $display("FAIL no_periodic: got done after edge %0d required none in 200 cycles", first_done);
        end
`endif
    endtask

    task automatic test_saturate();
        logic [15:0] exp_cnt [4];
        do_reset();
        id_word = 32'h0;
        ts_word = TS_GOOD;
        exp_cnt[0] = 16'hFFFE;
        exp_cnt[1] = 16'hFFFF;
        exp_cnt[2] = 16'hFFFF;
        exp_cnt[3] = 16'hFFFF;
        // Preload near the limit instead of running ~65k checks.
        @(negedge clock);
        force dut.check_count_q = 16'hFFFD;
        #1 release dut.check_count_q;
        @(negedge clock);
        tests_run++;
        if (check_count !== 16'hFFFD) begin
            tests_failed++;
            $display("FAIL sat_preload: got %h required fffd", check_count);
        end
        for (int k = 0; k < 4; k++) begin
            run_check("sat");
            tests_run++;
            if (check_count !== exp_cnt[k]) begin
                tests_failed++;
                $display("FAIL sat_count_%0d: got %h required %h", k, check_count, exp_cnt[k]);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        id_word      = 32'h0;
        ts_word      = TS_GOOD;
        test_reset();
        test_basic();
        test_mismatch();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_periodic();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
